capture_reg_arbiter: RTL and testbench



---
 rtl/capture_reg_arbiter_if.sv | 21 ++
 rtl/capture_reg_arbiter.sv | 80 ++++++++
 tb/tb_capture_reg_arbiter.sv | 117 +++++++++++
 3 files changed

// File: rtl/capture_reg_arbiter_if.sv
// capture_reg_arbiter_if: two producer ports and one consumer port of the capture arbiter
interface capture_reg_arbiter_if #(parameter int WIDTH = 4);
  logic [WIDTH-1:0] I0_data;
  logic             I0_valid;
  logic             I0_ready;
  logic [WIDTH-1:0] I1_data;
  logic             I1_valid;
  logic             I1_ready;
  logic [WIDTH-1:0] O_data;
  logic             O_valid;
  logic             O_src;
  logic             O_ready;
  modport master (
    output I0_data, I0_valid, I1_data, I1_valid, O_ready,
    input  I0_ready, I1_ready, O_data, O_valid, O_src
  );
  modport slave (
    input  I0_data, I0_valid, I1_data, I1_valid, O_ready,
    output I0_ready, I1_ready, O_data, O_valid, O_src
  );
endinterface

// File: rtl/capture_reg_arbiter.sv
// capture_reg_arbiter: round-robin, burst-limited two-source arbiter feeding one capture register; ASSERT_ON_EN adds a protocol checker
`ifdef ASSERT_ON_EN
module capture_reg_arbiter_chk #(parameter int WIDTH = 4, parameter int BURST = 4) (
  input logic             clk,
  input logic             rst,
  input logic [WIDTH-1:0] i0_data,
  input logic             i0_valid,
  input logic             i0_ready,
  input logic [WIDTH-1:0] i1_data,
  input logic             i1_valid,
  input logic             i1_ready,
  input logic [WIDTH-1:0] o_data,
  input logic             o_valid,
  input logic             o_src,
  input logic             o_ready,
  input logic [3:0]       burst_cnt
);
  logic p_ok, p_hold, p_src, p_w0, p_w1;
  logic [WIDTH-1:0] p_od, p_d0, p_d1;
  always_ff @(posedge clk) begin
    p_ok <= !rst;
    p_hold <= o_valid & !o_ready;
    p_od <= o_data;
    p_src <= o_src;
    p_w0 <= i0_valid & !i0_ready;
    p_w1 <= i1_valid & !i1_ready;
    p_d0 <= i0_data;
    p_d1 <= i1_data;
    if (!rst) begin
      assert (!(i0_ready & i1_ready)) else $error("arbiter: both readies high");
      assert (burst_cnt <= 4'(BURST)) else $error("arbiter: burst_cnt above limit");
      if (p_ok & p_hold) assert (o_data == p_od && o_src == p_src) else $error("arbiter: held beat changed");
      if (p_ok & p_w0) assert (i0_valid && i0_data == p_d0) else $error("arbiter: source 0 withdrew beat");
      if (p_ok & p_w1) assert (i1_valid && i1_data == p_d1) else $error("arbiter: source 1 withdrew beat");
    end
  end
endmodule
`endif

module capture_reg_arbiter #(parameter int WIDTH = 4, parameter int BURST = 4) (
  input logic                 CLK,
  input logic                 RESET,
  capture_reg_arbiter_if.slave bus
);
  logic       owner, load, win;
  logic [3:0] burst_cnt;
  always_comb begin
    load = !bus.O_valid | bus.O_ready;
    win = (bus.I0_valid & bus.I1_valid) ? ((burst_cnt < 4'(BURST)) ? owner : !owner) : bus.I1_valid;
    bus.I0_ready = !RESET & load & bus.I0_valid & !win;
    bus.I1_ready = !RESET & load & bus.I1_valid & win;
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      bus.O_data <= '0;
      bus.O_valid <= 1'b0;
      bus.O_src <= 1'b0;
      owner <= 1'b0;
      burst_cnt <= 4'd0;
    end else if (load) begin
      bus.O_valid <= bus.I0_valid | bus.I1_valid;
      if (bus.I0_valid | bus.I1_valid) begin
        bus.O_data <= win ? bus.I1_data : bus.I0_data;
        bus.O_src <= win;
        owner <= win;
        burst_cnt <= (win != owner) ? 4'd1 : (burst_cnt == 4'(BURST)) ? burst_cnt : burst_cnt + 4'd1;
      end
    end
  end
`ifdef ASSERT_ON_EN
  capture_reg_arbiter_chk #(.WIDTH(WIDTH), .BURST(BURST)) u_chk (
    .clk(CLK), .rst(RESET),
    .i0_data(bus.I0_data), .i0_valid(bus.I0_valid), .i0_ready(bus.I0_ready),
    .i1_data(bus.I1_data), .i1_valid(bus.I1_valid), .i1_ready(bus.I1_ready),
    .o_data(bus.O_data), .o_valid(bus.O_valid), .o_src(bus.O_src), .o_ready(bus.O_ready),
    .burst_cnt(burst_cnt)
  );
`else
`endif
endmodule

// File: tb/tb_capture_reg_arbiter.sv
// tb_capture_reg_arbiter: directed checks of reset, burst rotation, idle resume, streaming, backpressure and mid-beat reset
module tb_capture_reg_arbiter;
  logic clk = 1'b0;
  logic rst;
  int n_cmp = 0;
  int n_err = 0;
  capture_reg_arbiter_if #(.WIDTH(4)) bus();
  capture_reg_arbiter #(.WIDTH(4), .BURST(4)) dut (.CLK(clk), .RESET(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [8:0] burst_seq;
    logic [3:0] resume_seq;
    logic [3:0] stream [3];
    burst_seq = 9'b0_1111_0000;
    resume_seq = 4'b1000;
    stream[0] = 4'h3;
    stream[1] = 4'h5;
    stream[2] = 4'h7;
    rst = 1'b1;
    bus.I0_valid = 1'b1;
    bus.I1_valid = 1'b1;
    bus.I0_data = 4'h1;
    bus.I1_data = 4'h2;
    bus.O_ready = 1'b1;
    #1;
    chk("rst_rdy0", {7'd0, bus.I0_ready}, 8'd0);
    chk("rst_rdy1", {7'd0, bus.I1_ready}, 8'd0);
    tick();
    chk("rst_ovalid_c1", {7'd0, bus.O_valid}, 8'd0);
    tick();
    chk("rst_ovalid_c2", {7'd0, bus.O_valid}, 8'd0);
    chk("rst_odata", {4'd0, bus.O_data}, 8'd0);
    chk("rst_rdy0_c2", {7'd0, bus.I0_ready}, 8'd0);
    rst = 1'b0;
    #1;
    chk("tie_rdy0", {7'd0, bus.I0_ready}, 8'd1);
    chk("tie_rdy1", {7'd0, bus.I1_ready}, 8'd0);
    for (int i = 0; i < 9; i++) begin
      tick();
      chk($sformatf("burst_src%0d", i), {7'd0, bus.O_src}, {7'd0, burst_seq[i]});
      chk($sformatf("burst_data%0d", i), {4'd0, bus.O_data}, burst_seq[i] ? 8'h2 : 8'h1);
      chk($sformatf("burst_one_rdy%0d", i), {7'd0, bus.I0_ready & bus.I1_ready}, 8'd0);
    end
    bus.I0_valid = 1'b0;
    bus.I1_valid = 1'b0;
    #1;
    chk("idle_rdy", {6'd0, bus.I1_ready, bus.I0_ready}, 8'd0);
    tick();
    chk("idle_ovalid", {7'd0, bus.O_valid}, 8'd0);
    bus.I0_valid = 1'b1;
    bus.I1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("resume_src%0d", i), {7'd0, bus.O_src}, {7'd0, resume_seq[i]});
      chk($sformatf("resume_valid%0d", i), {7'd0, bus.O_valid}, 8'd1);
    end
    bus.I0_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.I1_data = stream[i];
      #1;
      chk($sformatf("stream_rdy0_%0d", i), {7'd0, bus.I0_ready}, 8'd0);
      chk($sformatf("stream_rdy1_%0d", i), {7'd0, bus.I1_ready}, 8'd1);
      tick();
      chk($sformatf("stream_data%0d", i), {4'd0, bus.O_data}, {4'd0, stream[i]});
      chk($sformatf("stream_src%0d", i), {7'd0, bus.O_src}, 8'd1);
    end
    bus.I1_data = 4'hA;
    tick();
    chk("bp_load", {4'd0, bus.O_data}, 8'hA);
    bus.O_ready = 1'b0;
    bus.I0_valid = 1'b1;
    bus.I0_data = 4'hC;
    bus.I1_data = 4'hB;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("bp_rdy%0d", i), {6'd0, bus.I1_ready, bus.I0_ready}, 8'd0);
      tick();
      chk($sformatf("bp_data%0d", i), {4'd0, bus.O_data}, 8'hA);
      chk($sformatf("bp_src%0d", i), {7'd0, bus.O_src}, 8'd1);
      chk($sformatf("bp_valid%0d", i), {7'd0, bus.O_valid}, 8'd1);
    end
    bus.O_ready = 1'b1;
    #1;
    chk("sat_rdy0", {7'd0, bus.I0_ready}, 8'd1);
    chk("sat_rdy1", {7'd0, bus.I1_ready}, 8'd0);
    tick();
    chk("sat_data", {4'd0, bus.O_data}, 8'hC);
    chk("sat_src", {7'd0, bus.O_src}, 8'd0);
    rst = 1'b1;
    #1;
    chk("midrst_rdy", {6'd0, bus.I1_ready, bus.I0_ready}, 8'd0);
    tick();
    chk("midrst_valid", {7'd0, bus.O_valid}, 8'd0);
    chk("midrst_data", {4'd0, bus.O_data}, 8'd0);
    chk("midrst_src", {7'd0, bus.O_src}, 8'd0);
    rst = 1'b0;
    bus.I0_valid = 1'b0;
    #1;
    chk("post_rst_rdy1", {7'd0, bus.I1_ready}, 8'd1);
    tick();
    chk("post_rst_data", {4'd0, bus.O_data}, 8'hB);
    chk("post_rst_src", {7'd0, bus.O_src}, 8'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
